// File: rtl/mdu_ctrl.sv
`timescale 1ns/1ps
// mdu_ctrl: sequencer for the HI/LO multiply/divide resource.
// Launches MULT/MULTU (and DIV/DIVU when built in), holds the result while a
// fixed-latency down-counter runs, then commits it to the architectural HI/LO.
// Also generates the D-stage stall for HI/LO-using instructions.
// Build option: define MDU_DIV_EN to include the divider (DIV/DIVU); without
// it op codes 3/4 behave as invalid no-ops.
module mdu_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        hilo_use_D,
   output logic        busy,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_load;
   logic             is_mul;
   logic             is_div;
   logic             long_op;
   logic             launch;
   logic             last;
   logic [63:0]      prod_s;
   logic [63:0]      prod_u;
   logic [31:0]      res_hi;
   logic [31:0]      res_lo;
   logic             res_wr;
   logic [31:0]      pend_hi;
   logic [31:0]      pend_lo;
   logic             pend_wr;

   // ------------------------------------------------------------------
   // Operation decode
   // ------------------------------------------------------------------
   assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_DIV_EN
   assign is_div = (op == OP_DIV) || (op == OP_DIVU);
`else
   assign is_div = 1'b0;
`endif
   assign long_op  = start & (is_mul | is_div);
   assign launch   = long_op & (state == IDLE);
   assign last     = (cnt == CNT_W'(1));
   assign cnt_load = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

   // ------------------------------------------------------------------
   // Result datapath (computed from a/b in the issue cycle)
   // ------------------------------------------------------------------
   assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
   assign prod_u = {32'b0, a} * {32'b0, b};

`ifdef MDU_DIV_EN
   logic [31:0] divs_b;
   logic [31:0] divu_b;
   logic [31:0] divs_q;
   logic [31:0] divs_r;
   logic [31:0] divu_q;
   logic [31:0] divu_r;

   // Substitute a divisor of 1 for the cases the divider must not see:
   // b=0 (result is discarded anyway) and 0x80000000/-1, whose architectural
   // answer (LO=dividend, HI=0) is exactly what dividing by 1 produces.
   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      divs_b = b;
      divu_b = b;
      if ((b == '0) || ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)))
         divs_b = 32'd1;
      if (b == '0)
         divu_b = 32'd1;
   end

   assign divs_q = $signed(a) / $signed(divs_b);
   assign divs_r = $signed(a) % $signed(divs_b);
   assign divu_q = a / divu_b;
   assign divu_r = a % divu_b;
`endif

   // Select the 64-bit result and whether it will be written at commit
   always_comb begin
      res_hi = prod_u[63:32];
      res_lo = prod_u[31:0];
      res_wr = 1'b1;
      case (op)
         OP_MULT: {res_hi, res_lo} = prod_s;
`ifdef MDU_DIV_EN
         OP_DIV: begin
            res_hi = divs_r;
            res_lo = divs_q;
            res_wr = (b != '0);
         end
         OP_DIVU: begin
            res_hi = divu_r;
            res_lo = divu_q;
            res_wr = (b != '0);
         end
`endif
         default: ;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   // State register
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state: leave IDLE on a launch, return when the count expires
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (launch) state_next = RUN;
         RUN:     if (last)   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs: busy while running; stall D on any in-flight or issuing op
   always_comb begin
      busy  = (state == RUN);
      stall = hilo_use_D & (busy | long_op);
   end

   // ------------------------------------------------------------------
   // Counter, pending result and architectural HI/LO
   // ------------------------------------------------------------------
   // Latch the result at launch, count down, commit when the count expires
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the pending result is reset too, so an aborted op leaves nothing to commit.
         cnt     <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
         pend_wr <= 1'b0;
         hi      <= '0;
         lo      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (launch) begin
                  cnt     <= cnt_load;
                  pend_hi <= res_hi;
                  pend_lo <= res_lo;
                  pend_wr <= res_wr;
               end else if (start && (op == OP_MTHI)) begin
                  hi <= a;
               end else if (start && (op == OP_MTLO)) begin
                  lo <= a;
               end
            end
            RUN: begin
               cnt <= cnt - CNT_W'(1);
               if (last && pend_wr) begin
                  hi <= pend_hi;
                  lo <= pend_lo;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multi-cycle sequencer for the HI/LO multiply/divide resource of the pipelined MIPS core. It accepts an MDU operation issued from the E stage, models the unit's fixed latency with a down-counter, and commits the result into the architectural HI/LO registers when the count expires. It also raises the D-stage stall whenever a HI/LO-using instruction would observe or disturb an in-flight operation. Its HI/LO outputs feed the E-stage mfhi/mflo path, and from there the M and W pipeline registers.

## Interface
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (≥1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (≥1)
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clock clk
- start  in  1  E-stage MDU instruction valid this cycle
- op  in  3  1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; other values are no-op
- a  in  32  rs operand (also MTHI/MTLO write data)
- b  in  32  rt operand
- hilo_use_D  in  1  D-stage instr is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- busy  out  1  operation in flight
- stall  out  1  stall D stage = hilo_use_D & (busy | (start & op in 1..4))
- hi  out  32  architectural HI
- lo  out  32  architectural LO

## Operation
- States: IDLE, RUN. Reset → IDLE, cnt=0, busy=0, hi=0, lo=0, pending result=0.
- IDLE & start & op∈{1..4}: compute 64-bit result combinationally from a, b at that edge and latch it into pending_hi/pending_lo; load cnt with MULT_CYCLES or DIV_CYCLES; → RUN.
- MULT: signed 32×32→64, HI=[63:32], LO=[31:0]. MULTU: unsigned.
- DIV: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend. DIVU: unsigned.
- Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (b=0): full DIV_CYCLES busy; HI/LO unchanged at commit.
- RUN: cnt decrements each cycle. When cnt==1, the next edge commits pending → hi/lo, cnt→0, → IDLE.
- IDLE & start & op=5/6: hi (or lo) ← a at that edge; no busy.
- start during RUN is ignored; the stall guarantees it never occurs.
- Invalid op with start is a no-op.
- reset in RUN aborts: the pending result is discarded and all outputs go to reset values.

## Timing
- start sampled at edge T0 (IDLE) → busy=1 from T0 through edge T0+N, where N is the latency; busy=0 after edge T0+N.
- hi/lo take the new values at edge T0+N, in the same edge that busy falls.
- stall is combinational from hilo_use_D, busy, start, op.
- In the issue cycle (before T0), stall already holds a dependent D instruction.
- An mfhi issued right after a MULT reads the new value on the first cycle stall is low.
- MTHI/MTLO: value visible on hi/lo the cycle after the issue edge.
- Back-to-back MULT: the second is held in D; it issues in the cycle busy=0 and starts at that edge.

## Configuration
- MDU_DIV_EN defined: DIV/DIVU are supported as specified.
- MDU_DIV_EN undefined: no divider is synthesized, and op 3/4 are treated as invalid (no busy, no stall contribution, HI/LO unchanged). MULT/MTHI/MTLO are unaffected.

## Test plan
- Reset, then MULT a=0xFFFFFFFF, b=2 → busy for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE; stall=1 while hilo_use_D=1 and busy=1.
- MULTU a=0xFFFFFFFF, b=2 → hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
- DIV a=7, b=0xFFFFFFFE (−2) → after 10 cycles lo=0xFFFFFFFD, hi=0x00000001. DIVU a=7, b=0 → hi/lo unchanged, busy for 10 cycles.
- MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 → hi and lo update one cycle after each issue; busy stays 0.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- MULT in flight, assert reset at cnt=3 → busy=0, hi=lo=0, and no later commit.
- With MDU_DIV_EN undefined, DIV a=7, b=2 → busy=0, stall=0, hi/lo unchanged.
